// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the front-panel time-setting path.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    COMMIT = 2'd3
  } set_state_t;

  function automatic int ms_cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Any out-of-range input restarts the field at 00.
  function automatic logic [5:0] bcd_hour_inc(input logic [1:0] t, input logic [3:0] u);
    logic [5:0] r;
    if ((t == 2'd3) || (u > 4'd9) || ((t == 2'd2) && (u >= 4'd3))) begin
      r = 6'd0;
    end else if (u == 4'd9) begin
      r = {t + 2'd1, 4'd0};
    end else begin
      r = {t, u + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] bcd_min_inc(input logic [2:0] t, input logic [3:0] u);
    logic [6:0] r;
    if ((t > 3'd5) || (u > 4'd9) || ((t == 3'd5) && (u == 4'd9))) begin
      r = 7'd0;
    end else if (u == 4'd9) begin
      r = {t + 3'd1, 4'd0};
    end else begin
      r = {t, u + 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter, 1-cycle pulse on the debounced press.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEB_CYC = 20000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn_n,
  output logic o_level,
  output logic o_press
);

  localparam int CW = ms_cnt_w(DEB_CYC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_diff;
  logic          w_settle;

  assign w_diff   = r_sync2 ^ r_level;
  assign w_settle = w_diff && (r_cnt == CNT_LAST);

  // Level only follows the synchronised input after it has held still long enough.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= {CW{1'b0}};
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= w_settle && r_level;
      if (!w_diff) begin
        r_cnt <= {CW{1'b0}};
      end else if (w_settle) begin
        r_cnt   <= {CW{1'b0}};
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time-setting controller: edit FSM, auto-repeat, blink and idle abort.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 1_000_000,
  parameter int DEB_MS     = 20,
  parameter int HOLD_MS    = 600,
  parameter int REPEAT_MS  = 150,
  parameter int BLINK_MS   = 250,
  parameter int TIMEOUT_MS = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_mode_n,
  input  logic       btn_inc_n,
  input  logic [1:0] cur_hour_t,
  input  logic [3:0] cur_hour_u,
  input  logic [2:0] cur_min_t,
  input  logic [3:0] cur_min_u,
  output logic       run_en,
  output logic       set_load,
  output logic [1:0] set_hour_t,
  output logic [3:0] set_hour_u,
  output logic [2:0] set_min_t,
  output logic [3:0] set_min_u,
  output logic [1:0] blink_mask
);

  localparam int TICK_DIV = CLK_HZ / 1000;
  localparam int DEB_CYC  = (DEB_MS * CLK_HZ) / 1000;
  localparam int TW = ms_cnt_w(TICK_DIV);
  localparam int HW = ms_cnt_w(HOLD_MS);
  localparam int RW = ms_cnt_w(REPEAT_MS);
  localparam int BW = ms_cnt_w(BLINK_MS);
  localparam int IW = ms_cnt_w(TIMEOUT_MS);
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_MS - 1);
  localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_MS - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_MS - 1);
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT_MS - 1);

  set_state_t    r_state;
  set_state_t    w_state_nxt;
  logic          r_run_en, r_set_load;
  logic [1:0]    r_hour_t;
  logic [3:0]    r_hour_u;
  logic [2:0]    r_min_t;
  logic [3:0]    r_min_u;
  logic [1:0]    r_mask;
  logic [TW-1:0] r_tick_cnt;
  logic          r_tick;
  logic [HW-1:0] r_hold_cnt;
  logic [RW-1:0] r_rep_cnt;
  logic          r_rep_on;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink_off;
  logic [IW-1:0] r_idle_cnt;

  logic       w_press_mode, w_press_inc, w_mode_level, w_inc_level;
  logic       w_edit, w_entry, w_hold_act, w_repeat, w_inc_evt, w_timeout, w_bump;
  logic       w_run_en_nxt, w_set_load_nxt;
  logic [5:0] w_hour_nxt;
  logic [6:0] w_min_nxt;
  logic [1:0] w_mask_nxt;

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_mode (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn_n (btn_mode_n),
    .o_level (w_mode_level),
    .o_press (w_press_mode)
  );

  btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_inc (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_btn_n (btn_inc_n),
    .o_level (w_inc_level),
    .o_press (w_press_inc)
  );

  assign w_edit     = (r_state == EDIT_H) || (r_state == EDIT_M);
  assign w_entry    = (w_state_nxt != r_state);
  assign w_hold_act = w_edit && !w_inc_level && w_mode_level;
  assign w_repeat   = w_hold_act && r_tick &&
                      (r_rep_on ? (r_rep_cnt == REP_LAST) : (r_hold_cnt == HOLD_LAST));
  assign w_inc_evt  = w_press_inc || w_repeat;
  assign w_timeout  = w_edit && r_tick && (r_idle_cnt == IDLE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= {TW{1'b0}};
      r_tick     <= 1'b0;
    end else if (r_tick_cnt == TICK_LAST) begin
      r_tick_cnt <= {TW{1'b0}};
      r_tick     <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
      r_tick     <= 1'b0;
    end
  end

  // First repeat after HOLD_MS of continuous hold, then one every REPEAT_MS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= {HW{1'b0}};
      r_rep_cnt  <= {RW{1'b0}};
      r_rep_on   <= 1'b0;
    end else if (!w_hold_act) begin
      r_hold_cnt <= {HW{1'b0}};
      r_rep_cnt  <= {RW{1'b0}};
      r_rep_on   <= 1'b0;
    end else if (r_tick) begin
      if (!r_rep_on) begin
        if (w_repeat) begin
          r_rep_on   <= 1'b1;
          r_hold_cnt <= {HW{1'b0}};
        end else begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end else if (w_repeat) begin
        r_rep_cnt <= {RW{1'b0}};
      end else begin
        r_rep_cnt <= r_rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= {IW{1'b0}};
    end else if (w_press_mode || w_press_inc || w_repeat || w_entry || !w_edit) begin
      r_idle_cnt <= {IW{1'b0}};
    end else if (r_tick) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  // Blink restarts in the visible phase so the user sees each new value immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink_cnt <= {BW{1'b0}};
      r_blink_off <= 1'b0;
    end else if (w_entry || w_bump || !w_edit) begin
      r_blink_cnt <= {BW{1'b0}};
      r_blink_off <= 1'b0;
    end else if (r_tick) begin
      if (r_blink_cnt == BLINK_LAST) begin
        r_blink_cnt <= {BW{1'b0}};
        r_blink_off <= ~r_blink_off;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_run_en_nxt   = r_run_en;
    w_set_load_nxt = 1'b0;
    w_hour_nxt     = {r_hour_t, r_hour_u};
    w_min_nxt      = {r_min_t, r_min_u};
    w_bump         = 1'b0;
    case (r_state)
      RUN: begin
        if (w_press_mode) begin
          w_state_nxt  = EDIT_H;
          w_run_en_nxt = 1'b0;
          w_hour_nxt   = {cur_hour_t, cur_hour_u};
          w_min_nxt    = {cur_min_t, cur_min_u};
        end else begin
          w_state_nxt = RUN;
        end
      end
      EDIT_H: begin
        if (w_press_mode) begin
          w_state_nxt = EDIT_M;
        end else if (w_inc_evt) begin
          w_hour_nxt = bcd_hour_inc(r_hour_t, r_hour_u);
          w_bump     = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt  = RUN;
          w_run_en_nxt = 1'b1;
        end else begin
          w_state_nxt = EDIT_H;
        end
      end
      EDIT_M: begin
        if (w_press_mode) begin
          w_state_nxt = COMMIT;
        end else if (w_inc_evt) begin
          w_min_nxt = bcd_min_inc(r_min_t, r_min_u);
          w_bump    = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt  = RUN;
          w_run_en_nxt = 1'b1;
        end else begin
          w_state_nxt = EDIT_M;
        end
      end
      COMMIT: begin
        w_state_nxt    = RUN;
        w_set_load_nxt = 1'b1;
        w_run_en_nxt   = 1'b1;
      end
      default: begin
        w_state_nxt  = RUN;
        w_run_en_nxt = 1'b1;
      end
    endcase
  end

  always_comb begin
    w_mask_nxt = 2'b00;
    if (r_blink_off) begin
      case (r_state)
        EDIT_H:  w_mask_nxt = 2'b10;
        EDIT_M:  w_mask_nxt = 2'b01;
        default: w_mask_nxt = 2'b00;
      endcase
    end else begin
      w_mask_nxt = 2'b00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_run_en   <= 1'b1;
      r_set_load <= 1'b0;
      r_hour_t   <= 2'd0;
      r_hour_u   <= 4'd0;
      r_min_t    <= 3'd0;
      r_min_u    <= 4'd0;
      r_mask     <= 2'b00;
    end else begin
      r_state                <= w_state_nxt;
      r_run_en               <= w_run_en_nxt;
      r_set_load             <= w_set_load_nxt;
      {r_hour_t, r_hour_u}   <= w_hour_nxt;
      {r_min_t, r_min_u}     <= w_min_nxt;
      r_mask                 <= w_mask_nxt;
    end
  end

  assign run_en     = r_run_en;
  assign set_load   = r_set_load;
  assign set_hour_t = r_hour_t;
  assign set_hour_u = r_hour_u;
  assign set_min_t  = r_min_t;
  assign set_min_u  = r_min_u;
  assign blink_mask = r_mask;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl with 1 ms per clock and 4 ms debounce.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_mode_n, btn_inc_n;
  logic [1:0] cur_hour_t;
  logic [3:0] cur_hour_u;
  logic [2:0] cur_min_t;
  logic [3:0] cur_min_u;
  logic       run_en, set_load;
  logic [1:0] set_hour_t;
  logic [3:0] set_hour_u;
  logic [2:0] set_min_t;
  logic [3:0] set_min_u;
  logic [1:0] blink_mask;
  logic [12:0] set_all;

  int checks = 0;
  int errors = 0;
  int load_cnt = 0;
  logic [12:0] load_val = 13'd0;
  logic load_run_en = 1'b0;
  logic seen;

  time_set_ctrl #(
    .CLK_HZ(1000), .DEB_MS(4), .HOLD_MS(600), .REPEAT_MS(150), .BLINK_MS(250), .TIMEOUT_MS(10000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_mode_n(btn_mode_n), .btn_inc_n(btn_inc_n),
    .cur_hour_t(cur_hour_t), .cur_hour_u(cur_hour_u), .cur_min_t(cur_min_t), .cur_min_u(cur_min_u),
    .run_en(run_en), .set_load(set_load), .set_hour_t(set_hour_t), .set_hour_u(set_hour_u),
    .set_min_t(set_min_t), .set_min_u(set_min_u), .blink_mask(blink_mask)
  );

  always #5 clk = ~clk;

  assign set_all = {set_hour_t, set_hour_u, set_min_t, set_min_u};

  always @(negedge clk) begin
    if (set_load === 1'b1) begin
      load_cnt    = load_cnt + 1;
      load_val    = set_all;
      load_run_en = run_en;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [12:0] tv(input int ht, input int hu, input int mt, input int mu);
    return {2'(ht), 4'(hu), 3'(mt), 4'(mu)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tap_mode();
    btn_mode_n = 1'b0; cyc(12);
    btn_mode_n = 1'b1; cyc(12);
  endtask

  task automatic tap_inc();
    btn_inc_n = 1'b0; cyc(12);
    btn_inc_n = 1'b1; cyc(12);
  endtask

  task automatic set_cur(input int ht, input int hu, input int mt, input int mu);
    {cur_hour_t, cur_hour_u, cur_min_t, cur_min_u} = tv(ht, hu, mt, mu);
  endtask

  initial begin
    rst_n = 1'b0; btn_mode_n = 1'b1; btn_inc_n = 1'b1;
    set_cur(2, 1, 3, 7);
    cyc(3);
    chk("rst_run_en", 32'(run_en), 32'd1);
    chk("rst_mask", 32'(blink_mask), 32'd0);
    chk("rst_load", 32'(set_load), 32'd0);
    chk("rst_set", 32'(set_all), 32'd0);
    rst_n = 1'b1;
    cyc(20);
    chk("idle_run_en", 32'(run_en), 32'd1);
    chk("idle_no_load", 32'(load_cnt), 32'd0);

    // Basic edit: 21:37 -> hours 21,22,23,00 -> commit 00:37
    tap_mode();
    chk("snap_run_en", 32'(run_en), 32'd0);
    chk("snap_val", 32'(set_all), 32'(tv(2, 1, 3, 7)));
    set_cur(0, 5, 1, 2);
    tap_inc();
    chk("hour_22", 32'(set_all), 32'(tv(2, 2, 3, 7)));
    tap_inc();
    tap_inc();
    chk("hour_wrap_00", 32'(set_all), 32'(tv(0, 0, 3, 7)));
    tap_mode();
    chk("edit_m_run_en", 32'(run_en), 32'd0);
    chk("edit_m_no_load", 32'(load_cnt), 32'd0);
    tap_mode();
    chk("commit_load_once", 32'(load_cnt), 32'd1);
    chk("commit_val", 32'(load_val), 32'(tv(0, 0, 3, 7)));
    chk("commit_run_en", 32'(load_run_en), 32'd1);
    chk("after_commit_run", 32'(run_en), 32'd1);

    tap_inc();
    chk("run_inc_ignored", 32'(set_all), 32'(tv(0, 0, 3, 7)));
    chk("run_inc_no_load", 32'(load_cnt), 32'd1);

    // Auto-repeat in minutes from 58
    set_cur(1, 4, 5, 8);
    tap_mode();
    tap_mode();
    chk("hold_start", 32'(set_all), 32'(tv(1, 4, 5, 8)));
    btn_inc_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(1);
      if (set_min_u !== 4'd8) seen = 1'b1;
    end
    chk("hold_first_seen", 32'(seen), 32'd1);
    cyc(300);
    chk("hold_300_min59", 32'(set_all), 32'(tv(1, 4, 5, 9)));
    cyc(350);
    chk("hold_650_min00", 32'(set_all), 32'(tv(1, 4, 0, 0)));
    cyc(150);
    chk("hold_800_min01", 32'(set_all), 32'(tv(1, 4, 0, 1)));
    cyc(50);
    btn_inc_n = 1'b1;
    cyc(100);
    chk("hold_release_min01", 32'(set_all), 32'(tv(1, 4, 0, 1)));
    tap_mode();
    chk("hold_commit_cnt", 32'(load_cnt), 32'd2);
    chk("hold_commit_val", 32'(load_val), 32'(tv(1, 4, 0, 1)));

    // Bounce burst, carry 09->10, simultaneous MODE+INC, then reset mid-edit
    set_cur(0, 9, 0, 0);
    tap_mode();
    chk("bounce_snap", 32'(set_all), 32'(tv(0, 9, 0, 0)));
    btn_inc_n = 1'b0; cyc(1);
    btn_inc_n = 1'b1; cyc(1);
    btn_inc_n = 1'b0; cyc(20);
    btn_inc_n = 1'b1; cyc(15);
    chk("bounce_one_inc", 32'(set_all), 32'(tv(1, 0, 0, 0)));
    btn_mode_n = 1'b0; btn_inc_n = 1'b0;
    cyc(12);
    btn_mode_n = 1'b1; btn_inc_n = 1'b1;
    cyc(12);
    chk("mode_wins_hour", 32'(set_all), 32'(tv(1, 0, 0, 0)));
    tap_inc();
    chk("mode_wins_in_min", 32'(set_all), 32'(tv(1, 0, 0, 1)));
    rst_n = 1'b0;
    #1;
    chk("midrst_run_en", 32'(run_en), 32'd1);
    chk("midrst_set", 32'(set_all), 32'd0);
    chk("midrst_mask", 32'(blink_mask), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk("midrst_no_load", 32'(load_cnt), 32'd2);

    // Blink in EDIT_H with MODE held (single press), then idle abort
    set_cur(0, 8, 1, 5);
    btn_mode_n = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      cyc(1);
      if (run_en === 1'b0) seen = 1'b1;
    end
    chk("to_entry_seen", 32'(seen), 32'd1);
    cyc(100);
    chk("blink_on_100", 32'(blink_mask), 32'd0);
    cyc(275);
    chk("blink_off_375", 32'(blink_mask), 32'(2'b10));
    cyc(250);
    chk("blink_on_625", 32'(blink_mask), 32'd0);
    cyc(75);
    btn_mode_n = 1'b1;
    cyc(175);
    chk("blink_off_875", 32'(blink_mask), 32'(2'b10));
    cyc(9025);
    chk("to_9900_editing", 32'(run_en), 32'd0);
    cyc(200);
    chk("to_10100_run_en", 32'(run_en), 32'd1);
    chk("to_mask", 32'(blink_mask), 32'd0);
    chk("to_no_load", 32'(load_cnt), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
